fsm_sync_tx: RTL

//  Serial frame transmitter, transmit-side counterpart of the fsm_ab "101" sequence detector.

---
 rtl/fsm_sync_tx_pkg.sv | 35 +++
 rtl/fsm_sync_tx_piso_shift.sv | 36 +++
 rtl/fsm_sync_tx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fsm_sync_tx_pkg.sv
// ============================================================================
// Module   : fsm_sync_tx_pkg
// Brief    : Shared state encodings, sync marker and helpers for fsm_sync_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fsm_sync_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SYNC = 2'b01,
    ST_DATA = 2'b10,
    ST_GAP  = 2'b11
  } state_t;

  localparam int              SYNC_LEN     = 3;
  localparam logic [SYNC_LEN-1:0] SYNC_PATTERN = 3'b101;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Marker bits go out MSB-first, so index 0 maps to the top pattern bit.
  function automatic logic sync_bit(input logic [1:0] idx);
    logic [SYNC_LEN-1:0] pat;
    pat = SYNC_PATTERN;
    return pat[2'(SYNC_LEN-1) - idx];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fsm_sync_tx_piso_shift.sv
// ============================================================================
// Module   : fsm_sync_tx_piso_shift
// Brief    : Parallel-load, shift-left register presenting its MSB serially.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_sync_tx_piso_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] data_in,
  output logic              msb
);

  logic [DATA_W-1:0] r_shift;

  // Load wins over shift; a shift of a 1-bit register simply clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift <= '0;
    end else if (load) begin
      r_shift <= data_in;
    end else if (shift_en) begin
      r_shift <= r_shift << 1;
    end
  end

  assign msb = r_shift[DATA_W-1];

endmodule

`default_nettype wire

// File: rtl/fsm_sync_tx.sv
// ============================================================================
// Module   : fsm_sync_tx
// Brief    : Serial frame transmitter: 101 marker, MSB-first payload, zero gap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_sync_tx
  import fsm_sync_tx_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int GAP_BITS = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              out,
  output logic              frame_done,
  output logic [1:0]        state_out
);

  localparam int CNT_W = $clog2(max3(SYNC_LEN, DATA_W, GAP_BITS) + 1);

  localparam logic [CNT_W-1:0] c_sync_last = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] c_data_last = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'(GAP_BITS - 1);

  state_t           r_state;
  logic             r_out;
  logic             r_frame_done;
  logic [CNT_W-1:0] r_bit_cnt;

  logic             w_load;
  logic             w_shift_en;
  logic             w_msb;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc  = r_bit_cnt + 1'b1;
  assign w_load     = valid_in && (r_state == ST_IDLE);
  // Every edge that puts a payload bit on the line also advances the register.
  assign w_shift_en = ((r_state == ST_SYNC) && (r_bit_cnt == c_sync_last)) ||
                      (r_state == ST_DATA);

  fsm_sync_tx_piso_shift #(
    .DATA_W (DATA_W)
  ) u_piso (
    .clock    (clock),
    .reset    (reset),
    .load     (w_load),
    .shift_en (w_shift_en),
    .data_in  (data_in),
    .msb      (w_msb)
  );

  // Outputs are computed for the state being entered, so the line bit and
  // frame_done are valid in the same cycle as the state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_out        <= 1'b0;
      r_frame_done <= 1'b0;
      r_bit_cnt    <= '0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= '0;
          if (valid_in) begin
            r_state <= ST_SYNC;
            r_out   <= sync_bit(2'd0);
          end else begin
            r_out   <= 1'b0;
          end
        end
        ST_SYNC: begin
          if (r_bit_cnt == c_sync_last) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
            r_out     <= w_msb;
          end else begin
            r_bit_cnt <= w_cnt_inc;
            r_out     <= sync_bit(w_cnt_inc[1:0]);
          end
        end
        ST_DATA: begin
          if (r_bit_cnt == c_data_last) begin
            r_state      <= ST_GAP;
            r_bit_cnt    <= '0;
            r_out        <= 1'b0;
            r_frame_done <= (GAP_BITS == 1);
          end else begin
            r_bit_cnt <= w_cnt_inc;
            r_out     <= w_msb;
          end
        end
        ST_GAP: begin
          r_out <= 1'b0;
          if (r_bit_cnt == c_gap_last) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
          end else begin
            r_bit_cnt    <= w_cnt_inc;
            r_frame_done <= (w_cnt_inc == c_gap_last);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_bit_cnt <= '0;
          r_out     <= 1'b0;
        end
      endcase
    end
  end

  assign ready_out  = (r_state == ST_IDLE);
  assign out        = r_out;
  assign frame_done = r_frame_done;
  assign state_out  = r_state;

endmodule

`default_nettype wire
